// File: rtl/mc_control_fsm.sv
// mc_control_fsm
//   Main control FSM of the multicycle RV32I core. Walks the shared datapath
//   through fetch / decode / execute / memory / writeback, drives every mux
//   select and write enable, stalls on the unified memory's ready handshake,
//   traps on unsupported opcodes and counts retired instructions.
//
// Ports
//   clk, reset            core clock, synchronous active-high reset
//   Op, Funct3            instruction register fields (sampled in DECODE/BRANCH)
//   Zero                  ALU zero flag (branch resolution)
//   MemReady              memory completed the current access this cycle
//   PCWrite, IRWrite      PC load / IR+OldPC load enables
//   AdrSrc                memory address select (0 PC, 1 ALUOut)
//   MemWrite, RegWrite    data memory write strobe / register file write enable
//   ResultSrc             00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA               00 PC, 01 OldPC, 10 RD1
//   ALUSrcB               00 RD2, 01 ImmExt, 10 constant 4
//   ALUOp                 00 add, 01 subtract, 10 funct decode
//   IllegalOp             high while parked in TRAP
//   InstRetired           32-bit wrapping count of completed instructions
module mc_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  Op,
  input  logic [2:0]  Funct3,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        IllegalOp,
  output logic [31:0] InstRetired
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [3:0]  state_q, state_d;
  logic [31:0] retired_q, retired_d;
  // Load/store choice is captured in DECODE because Op is not guaranteed
  // stable once the FSM has left DECODE.
  logic        store_q, store_d;
  logic [3:0]  out_state;

  // ---------------- next state / counters ----------------
  always_comb begin
    state_d   = state_q;
    store_d   = store_q;
    retired_d = retired_q;
    case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        store_d = (Op == OP_STORE);
        case (Op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = (Funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = store_q ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
    // Every retiring path ends with a transition back into FETCH; only
    // FETCH itself (stalling) and reset can also land there.
    if (state_d == S_FETCH && state_q != S_FETCH)
      retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      store_q   <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      store_q   <= store_d;
      retired_q <= retired_d;
    end
  end

  // ---------------- output decode ----------------
  // While reset is high the outputs show FETCH's selects, so the datapath
  // sees a clean fetch the moment reset drops.
  assign out_state = reset ? S_FETCH : state_q;

  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    IllegalOp = 1'b0;
    case (out_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        // beq (funct3[0]=0) taken on Zero, bne (funct3[0]=1) on !Zero
        PCWrite = Zero ^ Funct3[0];
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_TRAP:     IllegalOp = 1'b1;
      default:    IllegalOp = 1'b1;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  assign InstRetired = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm. Each instruction is expanded into a list of
// expected per-cycle output vectors (one entry per clock) together with the
// inputs to drive that cycle; a single compare process checks every cycle.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  Op;
  logic [2:0]  Funct3;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, IllegalOp;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [31:0] InstRetired;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct3(Funct3), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .IllegalOp(IllegalOp), .InstRetired(InstRetired)
  );

  // exp = {PCWrite,IRWrite,AdrSrc,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,IllegalOp}
  typedef struct packed {
    logic        rst;
    logic        mr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic [13:0] exp;
    logic        retire;
  } cyc_t;

  cyc_t q[$];
  cyc_t cur;
  bit   active = 0;
  int   checks = 0;
  int   failures = 0;
  int   idx = 0;
  logic [31:0] model_cnt = 32'd0;

  function automatic logic [13:0] mk(input logic pcw, irw, adr, memw, regw,
                                     input logic [1:0] res, asrc, bsrc, aop,
                                     input logic ill);
    return {pcw, irw, adr, memw, regw, res, asrc, bsrc, aop, ill};
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  task automatic push(input logic rst, mr, input logic [6:0] op,
                      input logic [2:0] f3, input logic z,
                      input logic [13:0] e, input logic ret);
    cyc_t c;
    c.rst = rst; c.mr = mr; c.op = op; c.f3 = f3; c.z = z; c.exp = e; c.retire = ret;
    q.push_back(c);
  endtask

  // Op/Funct3/Zero are noise everywhere except where they are sampled.
  task automatic busy(input logic mr, input logic [13:0] e, input logic ret);
    push(1'b0, mr, rop(), 3'($urandom), 1'($urandom), e, ret);
  endtask

  task automatic fetch(input int w);
    for (int i = 0; i < w; i++) busy(1'b0, mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0), 1'b0);
    busy(1'b1, mk(1,1,0,0,0,2'b10,2'b00,2'b10,2'b00,0), 1'b0);
  endtask

  task automatic reset_cyc();
    push(1'b1, 1'($urandom), rop(), 3'($urandom), 1'($urandom),
         mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0), 1'b0);
  endtask

  task automatic aluwb();
    busy(1'($urandom), mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0), 1'b1);
  endtask

  // kind: 0 lw, 1 sw, 2 R-type, 3 I-type, 4 branch, 5 jal, 6 illegal opcode
  task automatic gen(input int kind, input int fw, input int mw,
                     input logic [2:0] bf3, input logic z, input int trapn);
    logic [6:0] op;
    logic [6:0] bad [4];
    bad[0] = 7'b1111111; bad[1] = 7'b0110111; bad[2] = 7'b0000000; bad[3] = 7'b1100111;
    case (kind)
      0: op = 7'b0000011;
      1: op = 7'b0100011;
      2: op = 7'b0110011;
      3: op = 7'b0010011;
      4: op = 7'b1100011;
      5: op = 7'b1101111;
      default: op = bad[$urandom_range(0, 3)];
    endcase
    fetch(fw);
    push(1'b0, 1'($urandom), op, (kind == 4) ? bf3 : 3'($urandom), 1'($urandom),
         mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0), 1'b0);
    if (kind == 6 || (kind == 4 && bf3[2:1] != 2'b00)) begin
      for (int i = 0; i < trapn; i++) busy(1'($urandom), mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1), 1'b0);
      reset_cyc();
      return;
    end
    case (kind)
      0, 1: begin
        busy(1'($urandom), mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0), 1'b0);
        if (kind == 0) begin
          for (int i = 0; i < mw; i++) busy(1'b0, mk(0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0), 1'b0);
          busy(1'b1, mk(0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0), 1'b0);
          busy(1'($urandom), mk(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,0), 1'b1);
        end else begin
          for (int i = 0; i < mw; i++) busy(1'b0, mk(0,0,1,1,0,2'b00,2'b00,2'b00,2'b00,0), 1'b0);
          busy(1'b1, mk(0,0,1,1,0,2'b00,2'b00,2'b00,2'b00,0), 1'b1);
        end
      end
      2: begin busy(1'($urandom), mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0), 1'b0); aluwb(); end
      3: begin busy(1'($urandom), mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,0), 1'b0); aluwb(); end
      4: push(1'b0, 1'($urandom), op, bf3, z,
              mk(z ^ bf3[0],0,0,0,0,2'b00,2'b10,2'b00,2'b01,0), 1'b1);
      5: begin busy(1'($urandom), mk(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,0), 1'b0); aluwb(); end
      default: ;
    endcase
  endtask

  task automatic pin_len(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL len_%s model=%0d expected=%0d", name, got, want);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (active) begin
      checks += 2;
      if ({PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ALUOp, IllegalOp} !== cur.exp) begin
        failures++;
        $display("FAIL outputs cyc=%0d got=%b want=%b", idx,
                 {PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ALUOp, IllegalOp}, cur.exp);
      end
      if (InstRetired !== model_cnt) begin
        failures++;
        $display("FAIL inst_retired cyc=%0d got=%0d want=%0d", idx, InstRetired, model_cnt);
      end
      if (cur.rst) model_cnt = 32'd0;
      else if (cur.retire) model_cnt = model_cnt + 32'd1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b1; Op = '0; Funct3 = '0; Zero = 1'b0; MemReady = 1'b0;

    // Directed sequences; literal lengths pin the model's cycle counts.
    reset_cyc();
    n = q.size(); gen(2, 0, 0, 3'b000, 1'b0, 0); pin_len("add", q.size() - n, 4);
    n = q.size(); gen(0, 2, 1, 3'b000, 1'b0, 0); pin_len("lw_wait", q.size() - n, 8);
    n = q.size(); gen(4, 0, 0, 3'b001, 1'b0, 0); pin_len("bne_taken", q.size() - n, 3);
    n = q.size(); gen(4, 0, 0, 3'b001, 1'b1, 0); pin_len("bne_not", q.size() - n, 3);
    n = q.size(); gen(4, 0, 0, 3'b000, 1'b1, 0); pin_len("beq_taken", q.size() - n, 3);
    n = q.size(); gen(5, 0, 0, 3'b000, 1'b0, 0); pin_len("jal", q.size() - n, 4);
    n = q.size(); gen(1, 0, 0, 3'b000, 1'b0, 0); pin_len("sw", q.size() - n, 4);
    n = q.size(); gen(0, 0, 0, 3'b000, 1'b0, 0); pin_len("lw", q.size() - n, 5);
    n = q.size(); gen(3, 1, 0, 3'b000, 1'b0, 0); pin_len("addi_wait", q.size() - n, 5);
    n = q.size(); gen(6, 0, 0, 3'b000, 1'b0, 10); pin_len("trap", q.size() - n, 13);
    // sw with reset landing in the middle of the write wait
    fetch(0);
    push(1'b0, 1'b1, 7'b0100011, 3'b010, 1'b0, mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0), 1'b0);
    busy(1'b1, mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0), 1'b0);
    busy(1'b0, mk(0,0,1,1,0,2'b00,2'b00,2'b00,2'b00,0), 1'b0);
    push(1'b1, 1'b0, rop(), 3'b000, 1'b0, mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0), 1'b0);
    gen(2, 0, 0, 3'b000, 1'b0, 0);

    // Random instruction mix
    for (int i = 0; i < 250; i++) begin
      int k;
      k = $urandom_range(0, 19);
      if (k < 3)       gen(0, $urandom_range(0, 3), $urandom_range(0, 3), 3'b000, 1'b0, 0);
      else if (k < 6)  gen(1, $urandom_range(0, 3), $urandom_range(0, 3), 3'b000, 1'b0, 0);
      else if (k < 9)  gen(2, $urandom_range(0, 2), 0, 3'b000, 1'b0, 0);
      else if (k < 12) gen(3, $urandom_range(0, 2), 0, 3'b000, 1'b0, 0);
      else if (k < 16) gen(4, $urandom_range(0, 2), 0, 3'($urandom_range(0, 1)), 1'($urandom), 0);
      else if (k < 18) gen(5, $urandom_range(0, 2), 0, 3'b000, 1'b0, 0);
      else if (k < 19) gen(4, 0, 0, 3'($urandom_range(2, 7)), 1'($urandom), $urandom_range(1, 4));
      else             gen(6, $urandom_range(0, 1), 0, 3'b000, 1'b0, $urandom_range(1, 4));
    end

    @(posedge clk);            // first edge with reset high
    foreach (q[i]) begin
      #1;
      idx = i;
      cur = q[i];
      reset = q[i].rst; MemReady = q[i].mr; Op = q[i].op; Funct3 = q[i].f3; Zero = q[i].z;
      active = 1;
      @(posedge clk);
    end
    #1 active = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Main control state machine for the multicycle RV32I core. It decodes the opcode held in the instruction register and steps the shared datapath through fetch, decode, execute, memory and writeback. It drives every mux select and write enable: PC, IR, register file, data memory, ALU operand selects, ALU op class and the result-select mux. It also stalls on a memory-ready handshake, traps on unsupported instructions and counts retired instructions.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- Op  in  7  opcode field of the instruction register
- Funct3  in  3  funct3 field of the instruction register (branch condition)
- Zero  in  1  ALU zero flag
- MemReady  in  1  unified memory has completed the current access this cycle
- PCWrite  out  1  PC register load enable
- IRWrite  out  1  instruction register and OldPC load enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write strobe
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  00 = add, 01 = subtract (compare), 10 = decode funct fields
- IllegalOp  out  1  sticky trap flag
- InstRetired  out  32  count of completed instructions

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- Any select not listed for a state is 00/0. Every enable not listed is 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - Hold while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by Op:
  - 0000011 -> MEMADR
  - 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH if Funct3 is 000 or 001, else TRAP
  - 1101111 -> JAL
  - any other Op -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: AdrSrc=1. Hold until MemReady=1, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held for the whole access. Go to FETCH on MemReady=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite=Zero^Funct3[0] (beq taken on Zero=1, bne on Zero=0). Then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 (PC <- target). Then ALUWB, which writes OldPC+4 to rd.
- TRAP: all enables 0, IllegalOp=1. State holds until reset.
- InstRetired increments by 1 (mod 2^32) on each clock edge that takes the FSM to FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH. JAL retires through its ALUWB.

## Timing
- Reset (reset=1 at an edge): state <- FETCH, InstRetired <- 0, IllegalOp <- 0.
  - While reset is high, PCWrite, IRWrite, RegWrite and MemWrite are forced 0. Other outputs show the FETCH values.
  - Reset overrides any state, including TRAP and a pending memory wait.
- All outputs are a decode of the current state. The exceptions are PCWrite/IRWrite in FETCH (also depend on MemReady) and PCWrite in BRANCH (also depends on Zero and Funct3). There is no registered output delay.
- Minimum cycles with MemReady=1 in FETCH: beq/bne 3; R-type, I-type ALU, jal and sw 4; lw 5.
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Outputs stay stable while waiting.
- Op and Funct3 are only sampled in DECODE and BRANCH. Changes at other times are ignored.

## Test plan
- Reset, then issue add (Op=0110011) with MemReady=1 -> states FETCH,DECODE,EXECR,ALUWB. RegWrite=1 only in cycle 4. InstRetired=1 after cycle 4.
- lw (Op=0000011) with MemReady=0 for 2 cycles in FETCH and 1 cycle in MEMREAD -> 8 cycles total. IRWrite pulses once. MEMWB has ResultSrc=01 and RegWrite=1.
- bne (Op=1100011, Funct3=001): Zero=0 -> PCWrite=1 in BRANCH. Zero=1 -> PCWrite=0. Both paths take 3 cycles and increment InstRetired.
- jal (Op=1101111) -> JAL cycle has PCWrite=1 and ALUSrcA=01. Next cycle is ALUWB with RegWrite=1. InstRetired increments once.
- Op=1111111 -> TRAP after DECODE. IllegalOp=1 and all enables 0 for 10 cycles. reset=1 for one cycle -> FETCH, IllegalOp=0, InstRetired=0.
- Preload InstRetired to 0xFFFFFFFF by running instructions, then retire one more -> counter wraps to 0. reset asserted mid-MEMWRITE wait -> MemWrite=0 at once, FETCH next cycle.
